// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequences one stride-1 convolution pass, issuing window read addresses and accumulator strobes.
// Optional PERF_CNT_EN adds a 16-bit saturating output-stall counter (stall_cnt).
module conv_window_ctrl #(
  parameter int IMA_SIZE = 6,
  parameter int IMA_ADDR = 3,
  parameter int CON_SIZE = 3,
  parameter int CON_ADDR = 2,
  parameter int FLT_ADDR = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                ima_rd_en,
  output logic [IMA_ADDR-1:0] ima_row,
  output logic [IMA_ADDR-1:0] ima_col,
  output logic                flt_rd_en,
  output logic [FLT_ADDR-1:0] flt_addr,
  output logic                acc_clr,
  output logic                acc_en,
  output logic                out_valid,
`ifdef PERF_CNT_EN
  output logic [15:0]         stall_cnt,
`endif
  output logic [IMA_ADDR-1:0] out_row,
  output logic [IMA_ADDR-1:0] out_col
);
  localparam int OUT_SIZE = IMA_SIZE - CON_SIZE + 1;
  localparam logic [CON_ADDR-1:0] OFF_LAST = CON_ADDR'(CON_SIZE - 1);
  localparam logic [IMA_ADDR-1:0] POS_LAST = IMA_ADDR'(OUT_SIZE - 1);

  typedef enum logic [2:0] {IDLE, LOAD, DRAIN, OUT, DONE} state_t;

  state_t              state, state_nxt;
  logic [CON_ADDR-1:0] off_row, off_col;
  logic                off_last, pos_last, hs;

  assign off_last = off_row == OFF_LAST && off_col == OFF_LAST;
  assign pos_last = out_row == POS_LAST && out_col == POS_LAST;
  assign hs       = state == OUT && out_ready;

  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  // Outputs decode from registered state only, so no input reaches an output combinationally
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = off_last ? DRAIN : LOAD;
      DRAIN:   state_nxt = OUT;
      OUT:     state_nxt = out_ready ? (pos_last ? DONE : LOAD) : OUT;
      default: state_nxt = IDLE;
    endcase
    busy      = state != IDLE;
    done      = state == DONE;
    ima_rd_en = state == LOAD;
    flt_rd_en = state == LOAD;
    out_valid = state == OUT;
    ima_row   = out_row + IMA_ADDR'(off_row);
    ima_col   = out_col + IMA_ADDR'(off_col);
    flt_addr  = FLT_ADDR'(off_row) * FLT_ADDR'(CON_SIZE) + FLT_ADDR'(off_col);
  end

  // acc strobes trail the read strobe by the one-cycle memory latency
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      off_row <= '0;
      off_col <= '0;
      out_row <= '0;
      out_col <= '0;
      acc_en  <= 1'b0;
      acc_clr <= 1'b0;
    end else begin
      acc_en  <= state == LOAD;
      acc_clr <= state == LOAD && off_row == '0 && off_col == '0;
      if (state == LOAD) begin
        off_col <= off_col == OFF_LAST ? '0 : off_col + 1'b1;
        if (off_col == OFF_LAST) off_row <= off_last ? '0 : off_row + 1'b1;
      end
      if (hs) begin
        out_col <= out_col == POS_LAST ? '0 : out_col + 1'b1;
        if (out_col == POS_LAST) out_row <= pos_last ? '0 : out_row + 1'b1;
      end
    end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset)                                                 stall_cnt <= '0;
    else if (state == IDLE && start)                            stall_cnt <= '0;
    else if (state == OUT && !out_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_conv_window_ctrl.sv
// tb_conv_window_ctrl: checks a 6x6/3x3 and a 4x4/2x2 instance cycle by cycle against a window/tick reference model.
module tb_conv_window_ctrl;
  localparam int NA = 4, CA = 3, NB = 3, CB = 2;

  logic clk = 1'b0, reset = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, rdy_a = 1'b1, rdy_b = 1'b1;
  logic busy_a, done_a, rd_a, frd_a, clr_a, en_a, ov_a;
  logic busy_b, done_b, rd_b, frd_b, clr_b, en_b, ov_b;
  logic [2:0] irow_a, icol_a, orow_a, ocol_a, irow_b, icol_b, orow_b, ocol_b;
  logic [3:0] fa_a;
  logic [1:0] fa_b;
`ifdef PERF_CNT_EN
  logic [15:0] stall_a, stall_b;
`endif
  logic [22:0] obs_a, obs_b;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int ph[2], w[2], t[2], stall[2], cyc_start[2], beats[2], dones[2], first_v[2], done_at[2];

  always #5 clk = ~clk;

  conv_window_ctrl dut_a (
    .clk(clk), .reset(reset), .start(start_a), .out_ready(rdy_a), .busy(busy_a), .done(done_a),
    .ima_rd_en(rd_a), .ima_row(irow_a), .ima_col(icol_a), .flt_rd_en(frd_a), .flt_addr(fa_a),
    .acc_clr(clr_a), .acc_en(en_a), .out_valid(ov_a),
`ifdef PERF_CNT_EN
    .stall_cnt(stall_a),
`endif
    .out_row(orow_a), .out_col(ocol_a));

  conv_window_ctrl #(.IMA_SIZE(4), .IMA_ADDR(3), .CON_SIZE(2), .CON_ADDR(2), .FLT_ADDR(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .out_ready(rdy_b), .busy(busy_b), .done(done_b),
    .ima_rd_en(rd_b), .ima_row(irow_b), .ima_col(icol_b), .flt_rd_en(frd_b), .flt_addr(fa_b),
    .acc_clr(clr_b), .acc_en(en_b), .out_valid(ov_b),
`ifdef PERF_CNT_EN
    .stall_cnt(stall_b),
`endif
    .out_row(orow_b), .out_col(ocol_b));

  assign obs_a = {busy_a, done_a, rd_a, frd_a, clr_a, en_a, ov_a, irow_a, icol_a, fa_a, orow_a, ocol_a};
  assign obs_b = {busy_b, done_b, rd_b, frd_b, clr_b, en_b, ov_b, irow_b, icol_b, 2'b00, fa_b, orow_b, ocol_b};

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, e);
    end
  endtask

  // Window w, tick t: ticks 0..k-1 read offset t, tick k drains, tick k+1 presents the result
  function automatic logic [22:0] exp_vec(input int i);
    int n, c, k, pr, pc, rr, rc, fa;
    logic rd, ae, ac, ov, bz, dn;
    n  = (i == 1) ? NB : NA;
    c  = (i == 1) ? CB : CA;
    k  = c * c;
    pr = (ph[i] == 1) ? w[i] / n : 0;
    pc = (ph[i] == 1) ? w[i] % n : 0;
    rd = ph[i] == 1 && t[i] < k;
    rr = pr + (rd ? t[i] / c : 0);
    rc = pc + (rd ? t[i] % c : 0);
    fa = rd ? t[i] : 0;
    ae = ph[i] == 1 && t[i] >= 1 && t[i] <= k;
    ac = ph[i] == 1 && t[i] == 1;
    ov = ph[i] == 1 && t[i] == k + 1;
    bz = ph[i] != 0;
    dn = ph[i] == 2;
    return {bz, dn, rd, rd, ac, ae, ov, 3'(rr), 3'(rc), 4'(fa), 3'(pr), 3'(pc)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ph[i] = 0; w[i] = 0; t[i] = 0; stall[i] = 0; cyc_start[i] = 0;
      beats[i] = 0; dones[i] = 0; first_v[i] = -1; done_at[i] = -1;
    end
  endtask

  task automatic update(input int i, input logic s, input logic r);
    int n, k;
    n = (i == 1) ? NB : NA;
    k = (i == 1) ? CB * CB : CA * CA;
    if (ph[i] == 0) begin
      if (s) begin
        ph[i] = 1; w[i] = 0; t[i] = 0; stall[i] = 0; cyc_start[i] = cyc;
        beats[i] = 0; dones[i] = 0; first_v[i] = -1; done_at[i] = -1;
      end
    end else if (ph[i] == 2) ph[i] = 0;
    else if (t[i] < k + 1) t[i]++;
    else if (!r) stall[i] = (stall[i] == 65535) ? 65535 : stall[i] + 1;
    else if (w[i] == n * n - 1) ph[i] = 2;
    else begin
      w[i]++;
      t[i] = 0;
    end
  endtask

  task automatic check_all();
    check("dut_a_outputs", 32'(obs_a), 32'(exp_vec(0)));
    check("dut_b_outputs", 32'(obs_b), 32'(exp_vec(1)));
`ifdef PERF_CNT_EN
    check("dut_a_stall_cnt", 32'(stall_a), 32'(stall[0]));
    check("dut_b_stall_cnt", 32'(stall_b), 32'(stall[1]));
`endif
  endtask

  // mode 0: ready high, 1: random ready, 2: ready low
  task automatic tick(input int mode);
    logic s_a, s_b;
    @(negedge clk);
    check_all();
    rdy_a = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    rdy_b = mode == 0 ? 1'b1 : mode == 2 ? 1'b0 : 1'($urandom_range(0, 3) != 0);
    if (ov_a && rdy_a) beats[0]++;
    if (ov_b && rdy_b) beats[1]++;
    if (ov_a && first_v[0] < 0) first_v[0] = cyc - cyc_start[0];
    if (ov_b && first_v[1] < 0) first_v[1] = cyc - cyc_start[1];
    if (done_a) begin dones[0]++; done_at[0] = cyc - cyc_start[0]; end
    if (done_b) begin dones[1]++; done_at[1] = cyc - cyc_start[1]; end
    s_a = start_a;
    s_b = start_b;
    @(posedge clk);
    #1;
    update(0, s_a, rdy_a);
    update(1, s_b, rdy_b);
    cyc++;
  endtask

  task automatic run_to_idle(input int mode, input string tag);
    int n = 0;
    while ((ph[0] != 0 || ph[1] != 0) && n < 2000) begin
      tick(mode);
      n++;
    end
    check({tag, "_terminates"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin
    int n;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) tick(0);

    start_a = 1'b1; start_b = 1'b1;
    tick(0);
    start_a = 1'b0; start_b = 1'b0;
    run_to_idle(0, "pass_ready_high");
    check("a_beats", beats[0], 16);
    check("a_first_valid_cycle", first_v[0], 11);
    check("a_done_cycle", done_at[0], 177);
    check("a_done_count", dones[0], 1);
    check("b_beats", beats[1], 9);
    check("b_first_valid_cycle", first_v[1], 6);
    check("b_done_cycle", done_at[1], 55);
    check("b_done_count", dones[1], 1);
    repeat (2) tick(0);

    start_a = 1'b1;
    tick(0);
    start_a = 1'b0;
    n = 0;
    while (!(ph[0] == 1 && t[0] == CA * CA + 1) && n < 100) begin tick(0); n++; end
    check("stall_reach_out", 32'(n < 100), 32'd1);
    repeat (5) tick(2);
    check("stall_out_pos", {orow_a, ocol_a}, 6'd0);
`ifdef PERF_CNT_EN
    check("stall_cnt_five", 32'(stall_a), 32'd5);
`endif
    tick(0);
    run_to_idle(1, "pass_after_stall");
    check("stall_pass_beats", beats[0], 16);
    check("stall_pass_dones", dones[0], 1);

    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    repeat (29) tick(1);
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    run_to_idle(1, "pass_ignored_start");
    check("ignored_start_beats", beats[0], 16);
    check("ignored_start_dones", dones[0], 1);

    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    n = 0;
    while (!(ph[0] == 1 && w[0] == 9 && t[0] == 4) && n < 1000) begin tick(1); n++; end
    check("reach_window_2_1", {orow_a, ocol_a}, {3'd2, 3'd1});
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    #1 reset = 1'b1;
    tick(1);
    start_a = 1'b1; start_b = 1'b1;
    tick(1);
    start_a = 1'b0; start_b = 1'b0;
    run_to_idle(1, "pass_after_reset");
    check("restart_a_beats", beats[0], 16);
    check("restart_b_beats", beats[1], 9);
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
Sequences one convolution pass of a CON_SIZE x CON_SIZE filter over an IMA_SIZE x IMA_SIZE image memory (stride 1, no padding).
For each output position it issues the CON_SIZE^2 image/filter read addresses and drives accumulator clear/enable. It then presents the output coordinate with a valid/ready handshake.
It sits between the top-level start/done control and the image memory, filter memory and MAC datapath.

Parameters:
IMA_SIZE, 6, image edge length in pixels
IMA_ADDR, 3, width of image row/column address
CON_SIZE, 3, filter edge length
CON_ADDR, 2, width of filter row/column offset
FLT_ADDR, 4, width of linear filter address; must satisfy 2^FLT_ADDR >= CON_SIZE^2
Derived (local): OUT_SIZE = IMA_SIZE - CON_SIZE + 1

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin a pass; sampled only in IDLE
out_ready  in  1  downstream accepts the current result
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last result is accepted
ima_rd_en  out  1  image memory read strobe
ima_row  out  IMA_ADDR  image row = out_row + off_row
ima_col  out  IMA_ADDR  image column = out_col + off_col
flt_rd_en  out  1  filter memory read strobe; identical to ima_rd_en
flt_addr  out  FLT_ADDR  off_row*CON_SIZE + off_col
acc_clr  out  1  accumulator loads the product instead of adding it
acc_en  out  1  accumulator update strobe
out_valid  out  1  accumulator result for (out_row, out_col) is final
out_row  out  IMA_ADDR  current output row
out_col  out  IMA_ADDR  current output column

Behaviour:
- Reset (asynchronous, any state): state = IDLE; all outputs 0; out_row, out_col, off_row and off_col = 0.
- State machine: IDLE, LOAD, DRAIN, OUT, DONE.
- IDLE: if start = 1, go to LOAD. Otherwise stay in IDLE.
- LOAD:
  - ima_rd_en = flt_rd_en = 1 every cycle.
  - off_col increments each cycle.
  - When off_col = CON_SIZE-1, off_col wraps to 0 and off_row increments.
  - The read with off_row = off_col = CON_SIZE-1 is the last one. After it, offsets return to 0 and the state goes to DRAIN.
  - LOAD therefore lasts exactly CON_SIZE^2 cycles.
- Memory read latency is 1 cycle, so acc_en is ima_rd_en registered by one cycle.
- acc_clr is high only together with the first acc_en of each window.
- DRAIN: single cycle; carries the final acc_en. Then go to OUT.
- OUT:
  - out_valid = 1. out_row and out_col are held stable until out_ready = 1.
  - On the handshake cycle (out_valid & out_ready), the position advances.
  - Position advance: out_col increments; when out_col = OUT_SIZE-1, it wraps to 0 and out_row increments.
  - If (out_row, out_col) = (OUT_SIZE-1, OUT_SIZE-1) on the handshake, go to DONE and reset both to 0. Otherwise go to LOAD.
- DONE: done = 1 for one cycle, then go to IDLE.
- start is ignored in every state except IDLE; busy is already 1 in those states.
- Timing with out_ready tied to 1:
  - Start sampled at edge 0; LOAD occupies cycles 1..CON_SIZE^2.
  - First out_valid occurs in cycle CON_SIZE^2+2.
  - Each subsequent window takes CON_SIZE^2+2 cycles.
- No combinational path from any input to any output. out_ready only affects the state on the next edge.
- Address arithmetic: ima_row and ima_col are computed in IMA_ADDR bits. Their maximum is IMA_SIZE-1, so they never overflow for legal parameters.

Optional Feature:
PERF_CNT_EN
- Defined: adds output stall_cnt (16 bits).
  - Cleared to 0 on reset and when start is accepted in IDLE.
  - Increments on every cycle with out_valid = 1 and out_ready = 0.
  - Saturates at 16'hFFFF.
- Not defined: the port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Defaults, out_ready = 1, single start pulse:
  - Exactly 16 out_valid beats, with (out_row, out_col) = (0,0),(0,1)..(3,3).
  - First out_valid in cycle 11 after start is sampled.
  - done pulses once, in cycle 177; busy returns to 0 the next cycle.
- Window (1,2) address check:
  - ima_row/ima_col sequence (1,2),(1,3),(1,4),(2,2)..(3,4).
  - flt_addr sequence 0..8.
  - acc_en lags ima_rd_en by 1; acc_clr only on the first acc_en.
- out_ready held low for 5 cycles at window (0,0):
  - out_valid stays 1 with out_row/out_col = 0/0.
  - No ima_rd_en during the stall; the handshake then advances to (0,1).
  - With PERF_CNT_EN defined, stall_cnt = 5.
- start pulsed at cycle 30 during a pass:
  - Ignored; the pass completes with exactly 16 outputs and one done pulse.
- reset asserted mid-LOAD of window (2,1):
  - All outputs are 0 immediately; state is IDLE.
  - A new start restarts at window (0,0) with off_row = off_col = 0.
- Parameter set IMA_SIZE = 4, CON_SIZE = 2, FLT_ADDR = 2:
  - 9 windows, 6 cycles each.
  - Last window addresses (2,2),(2,3),(3,2),(3,3).
